atm_ledger_arbiter: RTL and testbench

//  Shares one account ledger between NUM_TERM ATM terminals (atm_module instances).

---
 rtl/atm_ledger_arbiter.sv | 217 +++++++++++++++++++++
 tb/tb_atm_ledger_arbiter.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/atm_ledger_arbiter.sv
// Round-robin arbiter that serialises read-modify-write transactions from
// NUM_TERM ATM terminals onto one shared account ledger.
module atm_ledger_arbiter #(
  parameter int          NUM_TERM     = 4,
  parameter int          NUM_ACCOUNTS = 4,
  parameter logic [15:0] INIT_BALANCE = 16'h1000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_TERM-1:0]      req,
  input  logic [2*NUM_TERM-1:0]    op,
  input  logic [8*NUM_TERM-1:0]    card,
  input  logic [16*NUM_TERM-1:0]   amt,
  output logic [NUM_TERM-1:0]      ack,
  output logic                     rsp_valid,
  output logic [2:0]               rsp_id,
  output logic [15:0]              rsp_balance,
  output logic                     rsp_ok,
  output logic [7:0]               rsp_err,
  output logic                     busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ARB  = 2'd1;
  localparam logic [1:0] S_EXEC = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  localparam logic [1:0] OP_BAL = 2'b00;
  localparam logic [1:0] OP_WD  = 2'b01;
  localparam logic [1:0] OP_DEP = 2'b10;

  localparam logic [7:0] ERR_OK    = 8'h00;
  localparam logic [7:0] ERR_CARD  = 8'h01;
  localparam logic [7:0] ERR_FUNDS = 8'h02;
  localparam logic [7:0] ERR_OVF   = 8'h03;
  localparam logic [7:0] ERR_OP    = 8'h04;

  logic [1:0]          state_q, state_d;
  logic [2:0]          ptr_q, ptr_d;
  logic [2:0]          id_q, id_d;
  logic [1:0]          op_q, op_d;
  logic [7:0]          card_q, card_d;
  logic [15:0]         amt_q, amt_d;
  logic [15:0]         ledger_q [NUM_ACCOUNTS];
  logic [15:0]         ledger_d [NUM_ACCOUNTS];
  logic [NUM_TERM-1:0] ack_q, ack_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [2:0]          rsp_id_q, rsp_id_d;
  logic [15:0]         rsp_balance_q, rsp_balance_d;
  logic                rsp_ok_q, rsp_ok_d;
  logic [7:0]          rsp_err_q, rsp_err_d;

  // Scan starts just after the last served terminal so it becomes lowest priority.
  int          scan_idx;
  logic        grant_found;
  logic [2:0]  grant_id;
  logic [1:0]  grant_op;
  logic [7:0]  grant_card;
  logic [15:0] grant_amt;

  always_comb begin
    scan_idx    = 0;
    grant_found = 1'b0;
    grant_id    = '0;
    grant_op    = '0;
    grant_card  = '0;
    grant_amt   = '0;
    for (int i = 1; i <= NUM_TERM; i++) begin
      scan_idx = int'(ptr_q) + i;
      if (scan_idx >= NUM_TERM) scan_idx = scan_idx - NUM_TERM;
      if (!grant_found && req[scan_idx]) begin
        grant_found = 1'b1;
        grant_id    = 3'(scan_idx);
        grant_op    = op[scan_idx*2 +: 2];
        grant_card  = card[scan_idx*8 +: 8];
        grant_amt   = amt[scan_idx*16 +: 16];
      end
    end
  end

  logic        card_valid;
  logic [15:0] cur_bal;
  logic [16:0] dep_sum;
  logic [15:0] res_bal;
  logic        res_ok;
  logic [7:0]  res_err;

  always_comb begin
    card_valid = 32'(card_q) < NUM_ACCOUNTS;
    cur_bal    = '0;
    for (int a = 0; a < NUM_ACCOUNTS; a++) begin
      if (card_q == 8'(a)) cur_bal = ledger_q[a];
    end
    dep_sum = {1'b0, cur_bal} + {1'b0, amt_q};
    res_bal = cur_bal;
    res_ok  = 1'b0;
    res_err = ERR_OK;
    // Bad card outranks a reserved opcode, which outranks arithmetic errors.
    if (!card_valid) begin
      res_bal = '0;
      res_err = ERR_CARD;
    end else begin
      case (op_q)
        OP_BAL: res_ok = 1'b1;
        OP_WD: begin
          if (amt_q > cur_bal) begin
            res_err = ERR_FUNDS;
          end else begin
            res_bal = cur_bal - amt_q;
            res_ok  = 1'b1;
          end
        end
        OP_DEP: begin
          if (dep_sum[16]) begin
            res_err = ERR_OVF;
          end else begin
            res_bal = dep_sum[15:0];
            res_ok  = 1'b1;
          end
        end
        default: res_err = ERR_OP;
      endcase
    end
  end

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    id_d          = id_q;
    op_d          = op_q;
    card_d        = card_q;
    amt_d         = amt_q;
    ledger_d      = ledger_q;
    ack_d         = '0;
    rsp_valid_d   = 1'b0;
    rsp_id_d      = rsp_id_q;
    rsp_balance_d = rsp_balance_q;
    rsp_ok_d      = rsp_ok_q;
    rsp_err_d     = rsp_err_q;
    case (state_q)
      S_IDLE: if (|req) state_d = S_ARB;
      S_ARB: begin
        if (grant_found) begin
          id_d    = grant_id;
          op_d    = grant_op;
          card_d  = grant_card;
          amt_d   = grant_amt;
          ptr_d   = grant_id;
          state_d = S_EXEC;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_EXEC: begin
        rsp_valid_d   = 1'b1;
        rsp_id_d      = id_q;
        rsp_balance_d = res_bal;
        rsp_ok_d      = res_ok;
        rsp_err_d     = res_err;
        for (int t = 0; t < NUM_TERM; t++) begin
          ack_d[t] = (id_q == 3'(t));
        end
        state_d = S_RESP;
      end
      default: begin
        // The registered result doubles as the write-back value.
        if (rsp_ok_q && op_q != OP_BAL) begin
          for (int a = 0; a < NUM_ACCOUNTS; a++) begin
            if (card_q == 8'(a)) ledger_d[a] = rsp_balance_q;
          end
        end
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      ptr_q         <= 3'(NUM_TERM - 1);
      id_q          <= '0;
      op_q          <= '0;
      card_q        <= '0;
      amt_q         <= '0;
      ack_q         <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_id_q      <= '0;
      rsp_balance_q <= '0;
      rsp_ok_q      <= 1'b0;
      rsp_err_q     <= '0;
      for (int a = 0; a < NUM_ACCOUNTS; a++) ledger_q[a] <= INIT_BALANCE;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      id_q          <= id_d;
      op_q          <= op_d;
      card_q        <= card_d;
      amt_q         <= amt_d;
      ack_q         <= ack_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_id_q      <= rsp_id_d;
      rsp_balance_q <= rsp_balance_d;
      rsp_ok_q      <= rsp_ok_d;
      rsp_err_q     <= rsp_err_d;
      ledger_q      <= ledger_d;
    end
  end

  assign ack         = ack_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_id      = rsp_id_q;
  assign rsp_balance = rsp_balance_q;
  assign rsp_ok      = rsp_ok_q;
  assign rsp_err     = rsp_err_q;
  assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_atm_ledger_arbiter.sv
// Scoreboard bench for atm_ledger_arbiter: a reference ledger model queues the
// expected response for every request; a negedge monitor pops and compares.
module tb_atm_ledger_arbiter;

  localparam int NT = 4;
  localparam int NA = 4;

  typedef struct {
    logic [2:0]  id;
    logic [15:0] bal;
    logic        ok;
    logic [7:0]  err;
  } exp_t;

  logic            clk;
  logic            rst;
  logic [NT-1:0]   req_r;
  logic [2*NT-1:0] op_r;
  logic [8*NT-1:0] card_r;
  logic [16*NT-1:0] amt_r;
  logic [NT-1:0]   ack;
  logic            rsp_valid;
  logic [2:0]      rsp_id;
  logic [15:0]     rsp_balance;
  logic            rsp_ok;
  logic [7:0]      rsp_err;
  logic            busy;

  int   check_count = 0;
  int   pass_count  = 0;
  int   cyc         = 0;
  bit   mon_en      = 0;
  exp_t exp_q[$];
  exp_t mon_e;
  int   ack_ids[$];
  int   ack_cycs[$];
  int   m_ledger[NA];
  logic [NT-1:0] mon_exp_ack;

  atm_ledger_arbiter #(.NUM_TERM(NT), .NUM_ACCOUNTS(NA), .INIT_BALANCE(16'h1000)) dut (
    .clk(clk), .rst(rst), .req(req_r), .op(op_r), .card(card_r), .amt(amt_r),
    .ack(ack), .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_balance(rsp_balance),
    .rsp_ok(rsp_ok), .rsp_err(rsp_err), .busy(busy)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Reference ledger: computes the expected response and applies commits.
  function automatic void model_reset();
    for (int a = 0; a < NA; a++) m_ledger[a] = 32'h1000;
  endfunction

  function automatic void model_push(input int t, input logic [1:0] o, input logic [7:0] c, input logic [15:0] a);
    exp_t e;
    int cur, s;
    e.id = 3'(t);
    if (int'(c) >= NA) begin
      e.bal = 16'h0; e.ok = 0; e.err = 8'h01;
    end else begin
      cur = m_ledger[int'(c)];
      if (o == 2'b11) begin
        e.bal = 16'(cur); e.ok = 0; e.err = 8'h04;
      end else if (o == 2'b00) begin
        e.bal = 16'(cur); e.ok = 1; e.err = 8'h00;
      end else if (o == 2'b01) begin
        if (int'(a) > cur) begin
          e.bal = 16'(cur); e.ok = 0; e.err = 8'h02;
        end else begin
          m_ledger[int'(c)] = cur - int'(a);
          e.bal = 16'(cur - int'(a)); e.ok = 1; e.err = 8'h00;
        end
      end else begin
        s = cur + int'(a);
        if (s > 32'hFFFF) begin
          e.bal = 16'(cur); e.ok = 0; e.err = 8'h03;
        end else begin
          m_ledger[int'(c)] = s;
          e.bal = 16'(s); e.ok = 1; e.err = 8'h00;
        end
      end
    end
    exp_q.push_back(e);
  endfunction

  always @(negedge clk) begin
    if (mon_en) begin
      if (rsp_valid) begin
        ack_ids.push_back(int'(rsp_id));
        ack_cycs.push_back(cyc);
        check_count++;
        if (exp_q.size() == 0) begin
          $display("[TB] FAIL unexpected_rsp: got id=%0d bal=%h err=%h, required no response", rsp_id, rsp_balance, rsp_err);
        end else begin
          mon_e = exp_q.pop_front();
          if (rsp_id !== mon_e.id || rsp_balance !== mon_e.bal || rsp_ok !== mon_e.ok || rsp_err !== mon_e.err)
            $display("[TB] FAIL rsp_fields: got id=%0d bal=%h ok=%b err=%h, required id=%0d bal=%h ok=%b err=%h",
                     rsp_id, rsp_balance, rsp_ok, rsp_err, mon_e.id, mon_e.bal, mon_e.ok, mon_e.err);
          else pass_count++;
          check_count++;
          mon_exp_ack = '0;
          mon_exp_ack[mon_e.id] = 1'b1;
          if (ack !== mon_exp_ack)
            $display("[TB] FAIL ack_onehot: got %b, required %b", ack, mon_exp_ack);
          else pass_count++;
        end
      end else begin
        check_count++;
        if (ack !== '0) $display("[TB] FAIL ack_idle: got %b, required 0000", ack);
        else pass_count++;
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst   = 1;
    req_r = '0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 0;
    model_reset();
  endtask

  // Drives one terminal from idle, waits for its ack, then drops req.
  task automatic issue(input int t, input logic [1:0] o, input logic [7:0] c, input logic [15:0] a, input string name);
    int c0;
    bit got;
    @(negedge clk);
    op_r[t*2 +: 2]    = o;
    card_r[t*8 +: 8]  = c;
    amt_r[t*16 +: 16] = a;
    req_r[t]          = 1'b1;
    model_push(t, o, c, a);
    c0  = cyc;
    got = 0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (ack[t]) got = 1;
    end
    req_r[t] = 1'b0;
    check_count++;
    if (!got) begin
      $display("[TB] FAIL %s_timeout: got no ack in 20 cycles, required ack", name);
      exp_q.delete();
    end else if (cyc - c0 != 3) begin
      $display("[TB] FAIL %s_latency: got %0d cycles, required 3", name, cyc - c0);
    end else pass_count++;
  endtask

  task automatic test_reset();
    do_reset();
    mon_en = 1;
    check_count++;
    if (busy !== 1'b0 || rsp_valid !== 1'b0 || ack !== '0)
      $display("[TB] FAIL reset_ctrl: got busy=%b valid=%b ack=%b, required 0 0 0000", busy, rsp_valid, ack);
    else pass_count++;
    check_count++;
    if (rsp_id !== 3'd0 || rsp_balance !== 16'h0 || rsp_ok !== 1'b0 || rsp_err !== 8'h00)
      $display("[TB] FAIL reset_rsp: got id=%0d bal=%h ok=%b err=%h, required all 0", rsp_id, rsp_balance, rsp_ok, rsp_err);
    else pass_count++;
    issue(0, 2'b00, 8'd0, 16'h0000, "t0_balance");
  endtask

  task automatic test_withdraw();
    issue(1, 2'b01, 8'd1, 16'h0050, "t1_withdraw");
    issue(1, 2'b01, 8'd1, 16'h1000, "t1_withdraw_nsf");
    issue(1, 2'b00, 8'd1, 16'h0000, "t1_balance");
  endtask

  task automatic test_deposit();
    issue(2, 2'b10, 8'd2, 16'hF000, "t2_deposit_ovf");
    issue(2, 2'b10, 8'd2, 16'hEFFF, "t2_deposit_max");
    issue(3, 2'b10, 8'd2, 16'h0000, "t3_deposit_zero");
  endtask

  task automatic test_boundaries();
    issue(3, 2'b01, 8'd3, 16'h1000, "t3_withdraw_exact");
    issue(0, 2'b01, 8'd3, 16'h0001, "t0_withdraw_empty");
    issue(1, 2'b11, 8'h07, 16'h0010, "bad_card_and_op");
    issue(2, 2'b00, 8'd4, 16'h0000, "card_at_limit");
    issue(3, 2'b11, 8'd0, 16'h0010, "bad_op");
    issue(0, 2'b00, 8'd0, 16'h0000, "t0_recheck");
  endtask

  task automatic test_back_to_back();
    int order[5] = '{0, 1, 2, 3, 0};
    int start;
    do_reset();
    ack_ids.delete();
    ack_cycs.delete();
    @(negedge clk);
    op_r   = {2'b11, 2'b00, 2'b01, 2'b10};
    card_r = {8'd3, 8'd2, 8'd1, 8'd0};
    amt_r  = {16'h0000, 16'h0000, 16'h0010, 16'h0001};
    req_r  = 4'b1111;
    model_push(0, 2'b10, 8'd0, 16'h0001);
    model_push(1, 2'b01, 8'd1, 16'h0010);
    model_push(2, 2'b00, 8'd2, 16'h0000);
    model_push(3, 2'b11, 8'd3, 16'h0000);
    model_push(0, 2'b10, 8'd0, 16'h0001);
    start = cyc;
    while (ack_ids.size() < 5 && cyc - start < 40) @(negedge clk);
    req_r = '0;
    check_count++;
    if (ack_ids.size() < 5) begin
      $display("[TB] FAIL rr_timeout: got %0d acks, required 5", ack_ids.size());
      exp_q.delete();
    end else pass_count++;
    for (int i = 0; i < 5 && i < ack_ids.size(); i++) begin
      check_count++;
      if (ack_ids[i] != order[i]) $display("[TB] FAIL rr_order%0d: got id %0d, required %0d", i, ack_ids[i], order[i]);
      else pass_count++;
      if (i > 0) begin
        check_count++;
        if (ack_cycs[i] - ack_cycs[i-1] != 4)
          $display("[TB] FAIL rr_gap%0d: got %0d cycles, required 4", i, ack_cycs[i] - ack_cycs[i-1]);
        else pass_count++;
      end
    end
    issue(0, 2'b00, 8'd0, 16'h0000, "rr_t0_after");
  endtask

  task automatic test_req_drop();
    int seen = 0;
    @(negedge clk);
    op_r[5:4] = 2'b00; card_r[23:16] = 8'd2; req_r[2] = 1'b1;
    @(negedge clk);
    req_r[2] = 1'b0;
    check_count++;
    if (busy !== 1'b1) $display("[TB] FAIL drop_busy_arb: got %b, required 1", busy);
    else pass_count++;
    repeat (6) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    check_count++;
    if (seen != 0 || busy !== 1'b0) $display("[TB] FAIL drop_no_rsp: got %0d rsps busy=%b, required 0 rsps busy=0", seen, busy);
    else pass_count++;
  endtask

  task automatic test_reset_mid();
    int c0;
    int seen = 0;
    issue(0, 2'b01, 8'd0, 16'h0200, "pre_reset_withdraw");
    @(negedge clk);
    op_r[1:0] = 2'b01; card_r[7:0] = 8'd0; amt_r[15:0] = 16'h0100; req_r[0] = 1'b1;
    c0 = cyc;
    while (cyc < c0 + 2) @(negedge clk);
    check_count++;
    if (busy !== 1'b1) $display("[TB] FAIL mid_busy_exec: got %b, required 1", busy);
    else pass_count++;
    rst = 1;
    repeat (2) begin
      @(negedge clk);
      req_r[0] = 1'b0;
      if (rsp_valid || ack !== '0) seen++;
    end
    rst = 0;
    model_reset();
    repeat (5) begin
      @(negedge clk);
      if (rsp_valid || ack !== '0) seen++;
    end
    check_count++;
    if (seen != 0) $display("[TB] FAIL mid_no_ack: got %0d responses, required 0", seen);
    else pass_count++;
    issue(0, 2'b00, 8'd0, 16'h0000, "post_reset_balance");
  endtask

  initial begin
    rst = 1; req_r = '0; op_r = '0; card_r = '0; amt_r = '0;
    test_reset();
    test_withdraw();
    test_deposit();
    test_boundaries();
    test_back_to_back();
    test_req_drop();
    test_reset_mid();
    repeat (3) @(negedge clk);
    check_count++;
    if (exp_q.size() != 0) $display("[TB] FAIL leftover_expected: got %0d pending, required 0", exp_q.size());
    else pass_count++;
    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
